synchronizer_pulse_multi: RTL and testbench
===========================================

Name: synchronizer_pulse_multi

Overview:
Multi-channel pulse synchronizer that carries single-cycle events from clk_in to clk_out without loss. Each channel uses a toggle request/acknowledge handshake with a configurable synchronizer depth. A saturating per-channel pending counter queues events that arrive while a handshake is in flight. It replaces the single-channel, single-event pulse synchronizer in the status and control crossing paths of the tester.

Parameters:
CHANNELS, 4, number of independent event channels
SYNC_STAGES, 2, flops per synchronizer chain in each direction; legal range is 2 or more
PEND_WIDTH, 3, width of the per-channel pending counter; saturates at 2^PEND_WIDTH-1

Ports:
clk_in  input  1  source clock
clk_out  input  1  destination clock
reset_n  input  1  asynchronous, active-low; resets both domains
pulse_in  input  CHANNELS  clk_in domain; each cycle high counts as one event
overflow_clr  input  CHANNELS  clk_in domain; clears the sticky overflow bit
pulse_out  output  CHANNELS  clk_out domain; registered, one clk_out cycle per delivered event
busy  output  CHANNELS  clk_in domain; handshake in flight or pending>0
pending  output  CHANNELS*PEND_WIDTH  clk_in domain; queued events not yet launched; channel n occupies bits [n*PEND_WIDTH +: PEND_WIDTH]
overflow  output  CHANNELS  clk_in domain; sticky, set when an event is dropped

Behaviour:
- Channels are fully independent. There is no shared logic apart from the clocks and reset.
- Reset: all flops clear to 0 asynchronously, including the req and ack toggles. All outputs are 0. Reset deassertion is synchronized to each clock by upstream reset logic.
- Reset mid-operation: in-flight and pending events are discarded. No pulse_out appears after release, because all toggles restart equal.
- Source FSM per channel, clk_in domain:
  - IDLE: req_tgl == ack_sync.
  - WAIT_ACK: req_tgl != ack_sync.
  - Launch means flipping req_tgl. A launch occurs in any cycle where the FSM is IDLE, or where ack_sync becomes equal to req_tgl, and an event is available (pending>0 or pulse_in=1).
  - Pending events launch before a new pulse_in.
- Pending counter update each clk_in cycle:
  - +1 if pulse_in is accepted and not launched directly.
  - -1 if the launch is taken from pending.
  - pulse_in and a pending launch in the same cycle: count unchanged.
  - IDLE, pending==0, pulse_in=1: launch directly; count stays 0.
- Saturation: if pending == max, pulse_in=1 and no launch in that cycle, the event is dropped and overflow is set.
- Overflow: overflow_clr clears the bit. A set in the same cycle as overflow_clr wins.
- Forward path: req_tgl passes through SYNC_STAGES clk_out flops into req_sync. The dest register holds the previous req_sync. pulse_out <= req_sync ^ dest_reg.
- Forward latency: pulse_out asserts SYNC_STAGES+1 clk_out edges after the req_tgl flip, plus up to one clk_out period of phase uncertainty.
- Return path: req_sync is the ack toggle. It passes through SYNC_STAGES clk_in flops into ack_sync.
- Throughput: at most one event per round trip, approximately (SYNC_STAGES+1)*T_out + (SYNC_STAGES+1)*T_in.
- busy = (req_tgl != ack_sync) | (pending != 0).
- No combinational path between the two clock domains. Every crossing signal is a single toggle bit driven directly from a flop.

Test Plan:
1. CHANNELS=4, SYNC_STAGES=2, clk_in 125 MHz, clk_out 25 MHz; one-cycle pulse_in[0] -> exactly one pulse_out[0], one clk_out wide, within 4 clk_out edges; busy[0] falls after ack; channels 1-3 stay silent; pending[0] stays 0.
2. pulse_in[1] high 5 consecutive clk_in cycles, same clocks -> pending[1] peaks at 4; exactly 5 pulse_out[1] pulses; overflow[1] stays 0; busy[1] falls after the last ack.
3. pulse_in[2] high 10 consecutive cycles, PEND_WIDTH=3 -> first event launches directly; pending[2] saturates at 7; 2 events dropped; exactly 8 pulse_out[2] pulses; overflow[2]=1 and holds.
4. Continue from scenario 3: assert overflow_clr[2] for one cycle -> overflow[2]=0. Then force a drop in the same cycle as overflow_clr -> overflow stays 1. Then pulse_in in the same cycle the ack returns with pending=2 -> pending stays 2.
5. Assert reset_n low while pending[3]=3 and a handshake is in flight -> all outputs 0 immediately; after release, no pulse_out for 20 clk_out cycles.
6. Swap ratios (clk_in 25 MHz, clk_out 125 MHz); pulse all 4 channels in the same cycle -> exactly one pulse_out per channel, all within the same clk_out cycle; busy all clear within 2 round trips.

Source files
------------

// File: rtl/synchronizer_pulse_multi.sv
// Multi-channel lossless pulse synchronizer, clk_in -> clk_out.
// Each lane runs a toggle req/ack handshake and queues events in a saturating counter while a handshake is in flight.

module synchronizer_pulse_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_WIDTH  = 3
) (
    input  logic                  clk_in,
    input  logic                  clk_out,
    input  logic                  reset_n,
    input  logic                  i_pulse,
    input  logic                  i_ovf_clr,
    output logic                  o_pulse,
    output logic                  o_busy,
    output logic [PEND_WIDTH-1:0] o_pending,
    output logic                  o_overflow
);
    typedef enum logic {S_IDLE, S_WAIT_ACK} state_t;

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    logic                   r_req_tgl;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic [PEND_WIDTH-1:0]  r_pend;
    logic                   r_ovf;
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic                   r_dest;
    logic                   r_pulse_out;

    state_t                 w_state;
    logic                   w_have;
    logic                   w_launch;
    logic                   w_drop;
    logic                   w_req_nxt;
    logic                   w_ovf_nxt;
    logic [PEND_WIDTH-1:0]  w_pend_nxt;

    // The state is encoded by the toggle pair itself: equal toggles mean no handshake outstanding.
    always_comb begin
        w_state    = (r_req_tgl == r_ack_sync[SYNC_STAGES-1]) ? S_IDLE : S_WAIT_ACK;
        w_have     = (r_pend != '0);
        w_launch   = (w_state == S_IDLE) && (w_have || i_pulse);
        w_drop     = i_pulse && !w_launch && (r_pend == PEND_MAX);
        w_req_nxt  = r_req_tgl ^ w_launch;
        w_pend_nxt = r_pend;
        // Queued events go first; a same-cycle pulse then replaces the one taken out.
        if (w_launch && w_have && !i_pulse)
            w_pend_nxt = r_pend - 1'b1;
        else if (!w_launch && i_pulse && !w_drop)
            w_pend_nxt = r_pend + 1'b1;
        w_ovf_nxt  = w_drop | (r_ovf & ~i_ovf_clr);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_req_tgl  <= 1'b0;
            r_ack_sync <= '0;
            r_pend     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_req_tgl  <= w_req_nxt;
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], r_req_sync[SYNC_STAGES-1]};
            r_pend     <= w_pend_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    always_ff @(posedge clk_out or negedge reset_n) begin
        if (!reset_n) begin
            r_req_sync  <= '0;
            r_dest      <= 1'b0;
            r_pulse_out <= 1'b0;
        end else begin
            r_req_sync  <= {r_req_sync[SYNC_STAGES-2:0], r_req_tgl};
            r_dest      <= r_req_sync[SYNC_STAGES-1];
            r_pulse_out <= r_req_sync[SYNC_STAGES-1] ^ r_dest;
        end
    end

    assign o_pulse    = r_pulse_out;
    assign o_busy     = (w_state == S_WAIT_ACK) || w_have;
    assign o_pending  = r_pend;
    assign o_overflow = r_ovf;
endmodule

module synchronizer_pulse_multi #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PEND_WIDTH  = 3
) (
    input  logic                           clk_in,
    input  logic                           clk_out,
    input  logic                           reset_n,
    input  logic [CHANNELS-1:0]            pulse_in,
    input  logic [CHANNELS-1:0]            overflow_clr,
    output logic [CHANNELS-1:0]            pulse_out,
    output logic [CHANNELS-1:0]            busy,
    output logic [CHANNELS*PEND_WIDTH-1:0] pending,
    output logic [CHANNELS-1:0]            overflow
);
    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        synchronizer_pulse_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .PEND_WIDTH  (PEND_WIDTH)
        ) u_lane (
            .clk_in     (clk_in),
            .clk_out    (clk_out),
            .reset_n    (reset_n),
            .i_pulse    (pulse_in[g]),
            .i_ovf_clr  (overflow_clr[g]),
            .o_pulse    (pulse_out[g]),
            .o_busy     (busy[g]),
            .o_pending  (pending[g*PEND_WIDTH +: PEND_WIDTH]),
            .o_overflow (overflow[g])
        );
    end
endmodule

// File: tb/tb_synchronizer_pulse_multi.sv
// Bench for synchronizer_pulse_multi: directed burst table, hand-written corner sequences,
// and randomized bursts checked against an event-count model.

module tb_synchronizer_pulse_multi;
    localparam int CH = 4;
    localparam int SS = 2;
    localparam int PW = 3;

    logic              clk_in = 1'b0;
    logic              clk_out = 1'b0;
    logic              reset_n = 1'b0;
    logic [CH-1:0]     pulse_in = '0;
    logic [CH-1:0]     overflow_clr = '0;
    logic [CH-1:0]     pulse_out;
    logic [CH-1:0]     busy;
    logic [CH*PW-1:0]  pending;
    logic [CH-1:0]     overflow;

    int half_in  = 4;
    int half_out = 20;

    synchronizer_pulse_multi #(.CHANNELS(CH), .SYNC_STAGES(SS), .PEND_WIDTH(PW)) dut (
        .clk_in       (clk_in),
        .clk_out      (clk_out),
        .reset_n      (reset_n),
        .pulse_in     (pulse_in),
        .overflow_clr (overflow_clr),
        .pulse_out    (pulse_out),
        .busy         (busy),
        .pending      (pending),
        .overflow     (overflow)
    );

    always #(half_in)  clk_in  = ~clk_in;
    always #(half_out) clk_out = ~clk_out;

    // Pulse monitor: high-cycle count and rising-edge count per channel, plus clk_out cycle of the last rise.
    int            hi_cnt   [CH] = '{default: 0};
    int            rise_cnt [CH] = '{default: 0};
    int            rise_cyc [CH] = '{default: 0};
    int            ocyc = 0;
    logic [CH-1:0] prev_po = '0;

    always @(negedge clk_out) begin
        ocyc <= ocyc + 1;
        prev_po <= pulse_out;
        for (int c = 0; c < CH; c++) begin
            if (pulse_out[c]) hi_cnt[c] <= hi_cnt[c] + 1;
            if (pulse_out[c] && !prev_po[c]) begin
                rise_cnt[c] <= rise_cnt[c] + 1;
                rise_cyc[c] <= ocyc;
            end
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int hbase [CH];
    int rbase [CH];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int pend_of(input int c);
        return int'(pending[c*PW +: PW]);
    endfunction

    task automatic snap();
        for (int c = 0; c < CH; c++) begin
            hbase[c] = hi_cnt[c];
            rbase[c] = rise_cnt[c];
        end
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy != '0 && k < 400) begin
            @(negedge clk_in);
            k++;
        end
        chk({nm, "_idle_timeout"}, int'(busy != '0), 0);
        repeat (3) @(negedge clk_out);
    endtask

    task automatic chk_pulses(input string nm, input int c, input int exp);
        chk({nm, "_pulses"}, hi_cnt[c] - hbase[c], exp);
        chk({nm, "_rises"}, rise_cnt[c] - rbase[c], exp);
    endtask

    typedef struct {
        int ch;
        int len;
        int exp_pulses;
        int exp_peak;
        int exp_ovf;
    } vec_t;

    vec_t vecs [5];
    int   lens [CH];
    int   dly  [CH];

    initial begin
        int peak, t0, others, tot, j, acc;

        // Burst applied right after a clk_out edge, so no pending launch can land inside a 10-cycle burst.
        vecs[0] = '{ch: 0, len: 1,  exp_pulses: 1, exp_peak: 0, exp_ovf: 0};
        vecs[1] = '{ch: 1, len: 5,  exp_pulses: 5, exp_peak: 4, exp_ovf: 0};
        vecs[2] = '{ch: 2, len: 10, exp_pulses: 8, exp_peak: 7, exp_ovf: 1};
        vecs[3] = '{ch: 3, len: 3,  exp_pulses: 3, exp_peak: 2, exp_ovf: 0};
        vecs[4] = '{ch: 0, len: 8,  exp_pulses: 8, exp_peak: 7, exp_ovf: 0};

        repeat (3) @(negedge clk_in);
        chk("rst_pulse_out", int'(pulse_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_overflow", int'(overflow), 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_out);

        for (int v = 0; v < 5; v++) begin
            snap();
            peak = 0;
            @(posedge clk_out);
            t0 = ocyc;
            for (int t = 0; t <= vecs[v].len + 2; t++) begin
                @(negedge clk_in);
                if (t > 0 && pend_of(vecs[v].ch) > peak) peak = pend_of(vecs[v].ch);
                pulse_in[vecs[v].ch] = (t < vecs[v].len);
            end
            wait_idle($sformatf("vec%0d", v));
            chk_pulses($sformatf("vec%0d", v), vecs[v].ch, vecs[v].exp_pulses);
            chk($sformatf("vec%0d_peak", v), peak, vecs[v].exp_peak);
            chk($sformatf("vec%0d_ovf", v), int'(overflow[vecs[v].ch]), vecs[v].exp_ovf);
            chk($sformatf("vec%0d_pend_end", v), pend_of(vecs[v].ch), 0);
            others = 0;
            for (int c = 0; c < CH; c++)
                if (c != vecs[v].ch) others += hi_cnt[c] - hbase[c];
            chk($sformatf("vec%0d_silent", v), others, 0);
            if (vecs[v].len == 1)
                chk("vec_latency_le4", int'((rise_cyc[vecs[v].ch] - t0) <= 4), 1);
        end

        // Overflow clear, then set-wins against a same-cycle clear.
        @(negedge clk_in);
        overflow_clr[2] = 1'b1;
        @(negedge clk_in);
        overflow_clr[2] = 1'b0;
        chk("ovf_clr", int'(overflow[2]), 0);

        snap();
        @(posedge clk_out);
        for (int t = 0; t <= 10; t++) begin
            @(negedge clk_in);
            if (t == 9)  chk("ovf_on_drop", int'(overflow[2]), 1);
            if (t == 10) begin
                chk("ovf_set_wins", int'(overflow[2]), 1);
                chk("pend_sat", pend_of(2), 7);
            end
            pulse_in[2]     = (t < 10);
            overflow_clr[2] = (t == 9);
        end
        overflow_clr[2] = 1'b0;
        wait_idle("sat2");
        chk_pulses("sat2", 2, 8);

        // Pulse lands in the cycle the ack returns (relative edge 12) with two events queued.
        snap();
        @(posedge clk_out);
        for (int t = 0; t <= 13; t++) begin
            @(negedge clk_in);
            if (t == 12) chk("collide_pend_before", pend_of(2), 2);
            if (t == 13) chk("collide_pend_after", pend_of(2), 2);
            pulse_in[2] = (t < 3) || (t == 12);
        end
        wait_idle("collide");
        chk_pulses("collide", 2, 4);

        // Reset while ch3 has three queued events and a handshake outstanding.
        @(posedge clk_out);
        for (int t = 0; t <= 4; t++) begin
            @(negedge clk_in);
            pulse_in[3] = (t < 4);
        end
        chk("mid_pend3", pend_of(3), 3);
        chk("mid_busy3", int'(busy[3]), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_pulse_out", int'(pulse_out), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_pending", int'(pending), 0);
        chk("mid_rst_overflow", int'(overflow), 0);
        repeat (3) @(negedge clk_in);
        reset_n = 1'b1;
        snap();
        repeat (20) @(negedge clk_out);
        tot = 0;
        for (int c = 0; c < CH; c++) tot += hi_cnt[c] - hbase[c];
        chk("post_rst_silent", tot, 0);

        // Random bursts (up to 8 per channel, from idle): nothing may drop, every event is delivered,
        // and before any queued event can launch the queue equals accepted events minus the direct one.
        for (int it = 0; it < 6; it++) begin
            for (int c = 0; c < CH; c++) begin
                lens[c] = $urandom_range(0, 8);
                dly[c]  = $urandom_range(0, 3);
            end
            snap();
            for (int t = 0; t <= 13; t++) begin
                @(negedge clk_in);
                if (t > 0)
                    for (int c = 0; c < CH; c++) begin
                        j = (t - 1) - dly[c];
                        if (j <= 7) begin
                            acc = (j < 0) ? 0 : ((j + 1 < lens[c]) ? j + 1 : lens[c]);
                            chk($sformatf("rnd%0d_pend_c%0d", it, c), pend_of(c), (acc > 0) ? acc - 1 : 0);
                        end
                    end
                for (int c = 0; c < CH; c++)
                    pulse_in[c] = (t >= dly[c]) && (t < dly[c] + lens[c]);
            end
            pulse_in = '0;
            wait_idle($sformatf("rnd%0d", it));
            for (int c = 0; c < CH; c++) begin
                chk_pulses($sformatf("rnd%0d_c%0d", it, c), c, lens[c]);
                chk($sformatf("rnd%0d_ovf_c%0d", it, c), int'(overflow[c]), 0);
            end
        end

        // Slow source, fast destination: simultaneous events on all channels.
        half_in  = 20;
        half_out = 4;
        repeat (4) @(negedge clk_in);
        snap();
        pulse_in = '1;
        @(negedge clk_in);
        pulse_in = '0;
        repeat (8) @(negedge clk_in);
        chk("swap_busy_clear", int'(busy), 0);
        repeat (4) @(negedge clk_out);
        for (int c = 0; c < CH; c++) begin
            chk_pulses($sformatf("swap_c%0d", c), c, 1);
            chk($sformatf("swap_aligned_c%0d", c), rise_cyc[c], rise_cyc[0]);
        end

        for (int it = 0; it < 4; it++) begin
            for (int c = 0; c < CH; c++) begin
                lens[c] = $urandom_range(0, 8);
                dly[c]  = $urandom_range(0, 3);
            end
            snap();
            for (int t = 0; t <= 12; t++) begin
                @(negedge clk_in);
                for (int c = 0; c < CH; c++)
                    pulse_in[c] = (t >= dly[c]) && (t < dly[c] + lens[c]);
            end
            pulse_in = '0;
            wait_idle($sformatf("srnd%0d", it));
            for (int c = 0; c < CH; c++) begin
                chk_pulses($sformatf("srnd%0d_c%0d", it, c), c, lens[c]);
                chk($sformatf("srnd%0d_ovf_c%0d", it, c), int'(overflow[c]), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
